// File: rtl/bist_signature_analyzer.sv
// rtl/bist_signature_analyzer.sv - BIST output response analyser (MISR compaction and pass/fail check)
//
// Purpose:
//   Compacts circuit-under-test responses into a multiple-input signature
//   register while the BIST controller reports running, counts the compacted
//   cycles, and on finish compares signature and count against golden values.
//
// Ports:
//   clk        in   1      system clock, rising edge
//   reset      in   1      asynchronous active-low reset
//   init       in   1      arm a new run (priority over finish/running)
//   running    in   1      compact data_in on this cycle
//   finish     in   1      end of run, start the check
//   data_in    in   WIDTH  CUT response
//   signature  out  WIDTH  current MISR contents
//   cycle_cnt  out  CW     compacted cycles, saturating
//   sig_valid  out  1      result final, held until next init
//   pass       out  1      run matched GOLDEN and NCLOCK
//   fail       out  1      run mismatched or overran
module bist_signature_analyzer #(
  parameter int unsigned      WIDTH  = 16,
  parameter logic [WIDTH-1:0] POLY   = 16'h002D,
  parameter logic [WIDTH-1:0] SEED   = 16'h0000,
  parameter logic [WIDTH-1:0] GOLDEN = 16'h0000,
  parameter int unsigned      NCLOCK = 650,
  localparam int unsigned     CW     = $clog2(NCLOCK + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             running,
  input  logic             finish,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] signature,
  output logic [CW-1:0]    cycle_cnt,
  output logic             sig_valid,
  output logic             pass,
  output logic             fail
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    CHECK   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [CW-1:0] NCLOCK_C = CW'(NCLOCK);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] sig_n;
  logic             match;

  // Galois-style MISR step: shift left, fold the dropped MSB back via POLY,
  // then XOR in the parallel CUT response.
  assign sig_n = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ data_in;
  assign match = (sig_q == GOLDEN) && (cnt_q == NCLOCK_C) && !overrun_q;

  always_comb begin
    state_d   = state_q;
    sig_d     = sig_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    overrun_d = overrun_q;
    if (init) begin
      // A new run can be armed from any state; the init-cycle data is dropped.
      state_d   = COMPACT;
      sig_d     = SEED;
      cnt_d     = '0;
      valid_d   = 1'b0;
      pass_d    = 1'b0;
      fail_d    = 1'b0;
      overrun_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        COMPACT: begin
          if (running) begin
            sig_d = sig_n;
            if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + CW'(1);
            end
            // A beat beyond the expected length poisons the run for good.
            if (cnt_q == NCLOCK_C) begin
              overrun_d = 1'b1;
            end
          end
          if (finish) begin
            state_d = CHECK;
          end
        end
        CHECK: begin
          pass_d  = match;
          fail_d  = !match;
          valid_d = 1'b1;
          state_d = DONE;
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      sig_q     <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sig_q     <= sig_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      overrun_q <= overrun_d;
    end
  end

  assign signature = sig_q;
  assign cycle_cnt = cnt_q;
  assign sig_valid = valid_q;
  assign pass      = pass_q;
  assign fail      = fail_q;

endmodule

// File: tb/tb_bist_signature_analyzer.sv
// tb/tb_bist_signature_analyzer.sv - directed self-checking bench for bist_signature_analyzer
module tb_bist_signature_analyzer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        init = 1'b0;
  logic        running = 1'b0;
  logic        finish = 1'b0;
  logic [15:0] data_in = '0;

  logic [15:0] signature;
  logic [9:0]  cycle_cnt;
  logic        sig_valid, pass, fail;

  logic [3:0]  s_signature;
  logic [9:0]  s_cycle_cnt;
  logic        s_sig_valid, s_pass, s_fail;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bist_signature_analyzer u_dut (
    .clk       (clk),
    .reset     (reset),
    .init      (init),
    .running   (running),
    .finish    (finish),
    .data_in   (data_in),
    .signature (signature),
    .cycle_cnt (cycle_cnt),
    .sig_valid (sig_valid),
    .pass      (pass),
    .fail      (fail)
  );

  bist_signature_analyzer #(
    .WIDTH  (4),
    .POLY   (4'h3),
    .SEED   (4'h0),
    .GOLDEN (4'h0),
    .NCLOCK (650)
  ) u_small (
    .clk       (clk),
    .reset     (reset),
    .init      (init),
    .running   (running),
    .finish    (finish),
    .data_in   (data_in[3:0]),
    .signature (s_signature),
    .cycle_cnt (s_cycle_cnt),
    .sig_valid (s_sig_valid),
    .pass      (s_pass),
    .fail      (s_fail)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // init pulse, n running beats (data 1 on beat corrupt_at, else 0), finish
  // pulse, then two more edges before the result is read.
  task automatic do_run(input int n, input int corrupt_at);
    init = 1'b1;
    step();
    init = 1'b0;
    check_eq("init_clears_valid", {31'd0, sig_valid}, 32'd0);
    check_eq("init_clears_pass", {31'd0, pass}, 32'd0);
    for (int i = 0; i < n; i++) begin
      running = 1'b1;
      data_in = (i == corrupt_at) ? 16'h0001 : 16'h0000;
      step();
    end
    running = 1'b0;
    data_in = '0;
    finish  = 1'b1;
    step();
    finish  = 1'b0;
    check_eq("valid_low_in_check", {31'd0, sig_valid}, 32'd0);
    step();
    step();
  endtask

  logic [3:0] t2_data [5];
  logic [3:0] t2_sig  [5];

  initial begin
    t2_data = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    t2_sig  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3};

    // reset state
    step();
    step();
    check_eq("rst_sig", {16'd0, signature}, 32'd0);
    check_eq("rst_cnt", {22'd0, cycle_cnt}, 32'd0);
    check_eq("rst_flags", {29'd0, sig_valid, pass, fail}, 32'd0);
    reset = 1'b1;

    // running and finish in IDLE are ignored
    running = 1'b1;
    data_in = 16'h00FF;
    finish  = 1'b1;
    step();
    step();
    running = 1'b0;
    finish  = 1'b0;
    data_in = '0;
    check_eq("idle_ignore_cnt", {22'd0, cycle_cnt}, 32'd0);
    check_eq("idle_ignore_sig", {16'd0, signature}, 32'd0);
    step();
    check_eq("idle_ignore_valid", {31'd0, sig_valid}, 32'd0);

    // T2: MISR math on the 4-bit instance
    init = 1'b1;
    data_in = 16'h000F;
    step();
    init = 1'b0;
    check_eq("t2_seed", {28'd0, s_signature}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      running = 1'b1;
      data_in = {12'd0, t2_data[i]};
      step();
      check_eq($sformatf("t2_sig%0d", i), {28'd0, s_signature}, {28'd0, t2_sig[i]});
    end
    running = 1'b0;
    data_in = '0;
    check_eq("t2_cnt", {22'd0, s_cycle_cnt}, 32'd5);
    step();
    check_eq("t2_hold", {28'd0, s_signature}, 32'h3);

    // T1: reset mid-COMPACT clears everything without waiting for an edge
    running = 1'b1;
    data_in = 16'h1234;
    step();
    #2;
    reset = 1'b0;
    #1;
    check_eq("t1_sig", {16'd0, signature}, 32'd0);
    check_eq("t1_cnt", {22'd0, cycle_cnt}, 32'd0);
    check_eq("t1_small_sig", {28'd0, s_signature}, 32'd0);
    check_eq("t1_flags", {29'd0, sig_valid, pass, fail}, 32'd0);
    running = 1'b0;
    data_in = '0;
    step();
    reset = 1'b1;
    step();

    // T3: nominal run
    do_run(650, -1);
    check_eq("t3_valid", {31'd0, sig_valid}, 32'd1);
    check_eq("t3_pass", {31'd0, pass}, 32'd1);
    check_eq("t3_fail", {31'd0, fail}, 32'd0);
    check_eq("t3_cnt", {22'd0, cycle_cnt}, 32'd650);
    check_eq("t3_sig", {16'd0, signature}, 32'd0);

    // DONE ignores running and finish
    running = 1'b1;
    finish  = 1'b1;
    data_in = 16'hBEEF;
    step();
    step();
    running = 1'b0;
    finish  = 1'b0;
    data_in = '0;
    check_eq("done_hold_cnt", {22'd0, cycle_cnt}, 32'd650);
    check_eq("done_hold_sig", {16'd0, signature}, 32'd0);
    check_eq("done_hold_pass", {29'd0, sig_valid, pass, fail}, 32'b110);

    // T5: back-to-back run without reset
    do_run(650, -1);
    check_eq("t5_pass", {29'd0, sig_valid, pass, fail}, 32'b110);

    // T4: short and long runs
    do_run(649, -1);
    check_eq("t4_short_cnt", {22'd0, cycle_cnt}, 32'd649);
    check_eq("t4_short_res", {29'd0, sig_valid, pass, fail}, 32'b101);
    do_run(651, -1);
    check_eq("t4_long_cnt", {22'd0, cycle_cnt}, 32'd651);
    check_eq("t4_long_res", {29'd0, sig_valid, pass, fail}, 32'b101);

    // T6: a single corrupted beat leaves a nonzero signature
    do_run(650, 100);
    check_eq("t6_sig_nonzero", {31'd0, (signature != 16'd0)}, 32'd1);
    check_eq("t6_res", {29'd0, sig_valid, pass, fail}, 32'b101);

    // init has priority over finish and running in the same cycle
    init = 1'b1;
    step();
    init = 1'b0;
    running = 1'b1;
    step();
    step();
    init = 1'b1;
    finish = 1'b1;
    step();
    init = 1'b0;
    finish = 1'b0;
    running = 1'b0;
    check_eq("prio_cnt", {22'd0, cycle_cnt}, 32'd0);
    step();
    step();
    check_eq("prio_no_check", {29'd0, sig_valid, pass, fail}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
